// File: rtl/vc4_tx_poh.sv
// VC-4 assembly: walks the 9x261 grid on en_vc4, interleaves TUG-3 A/B/C, inserts POH/stuff, keeps B3.
// Latency 1 clk en_vc4 -> do_vld; no backpressure, paced only by en_vc4 (every clk allowed).
module vc4_tx_poh #(
    parameter int unsigned       WIDTH   = 8,
    parameter logic [WIDTH-1:0]  J1_BYTE = 8'h00,
    parameter logic [WIDTH-1:0]  C2_BYTE = 8'h02
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             txsof_i,
    input  logic             en_vc4_i,
    input  logic [WIDTH-1:0] dotug3_0_i,
    input  logic [WIDTH-1:0] dotug3_1_i,
    input  logic [WIDTH-1:0] dotug3_2_i,
    input  logic [3:0]       rei_cnt_i,
    input  logic             rdi_i,
    output logic             entug3_0_o,
    output logic             entug3_1_o,
    output logic             entug3_2_o,
    output logic [WIDTH-1:0] vc4dout_o,
    output logic             do_vld_o,
    output logic [1:0]       mfi_o,
    output logic             sof_err_o
);

    localparam logic [8:0] LAST_COL = 9'd260;
    localparam logic [3:0] LAST_ROW = 4'd8;

    logic [8:0]       col_q, col_d;
    logic [3:0]       row_q, row_d;
    logic [1:0]       k_q, k_d;
    logic [1:0]       mfi_q, mfi_d;
    logic             sync_q;
    logic [WIDTH-1:0] b3_acc_q, b3_acc_d;
    logic [WIDTH-1:0] b3_hold_q, b3_hold_d;
    logic [3:0]       rei_lat_q;
    logic             rdi_lat_q;
    logic [WIDTH-1:0] byte_q;
    logic             tug_sel_q;
    logic [1:0]       tug_k_q;
    logic             vld_q;
    logic             last_q;
    logic             sof_err_q;

    logic             sof;
    logic             slot_vld;
    logic             is_tug;
    logic             is_last;
    logic             is_j1;
    logic [8:0]       slot_col;
    logic [3:0]       slot_row;
    logic [3:0]       rei_clamp;
    logic [WIDTH-1:0] slot_byte;

    // A txsof slot is always J1, regardless of where the free-running counters think we are.
    assign sof       = txsof_i & en_vc4_i;
    assign slot_col  = sof ? 9'd0 : col_q;
    assign slot_row  = sof ? 4'd0 : row_q;
    assign slot_vld  = en_vc4_i & (sync_q | txsof_i);
    assign is_tug    = en_vc4_i & sync_q & ~txsof_i & (col_q >= 9'd3);
    assign is_last   = en_vc4_i & sync_q & ~txsof_i & (col_q == LAST_COL) & (row_q == LAST_ROW);
    assign is_j1     = slot_vld & (slot_col == 9'd0) & (slot_row == 4'd0);
    assign rei_clamp = (rei_cnt_i > 4'd8) ? 4'd8 : rei_cnt_i;

    assign entug3_0_o = is_tug & (k_q == 2'd0);
    assign entug3_1_o = is_tug & (k_q == 2'd1);
    assign entug3_2_o = is_tug & (k_q == 2'd2);

    always_comb begin
        slot_byte = '0;
        if (slot_col == 9'd0) begin
            case (slot_row)
                4'd0:    slot_byte = J1_BYTE;
                4'd1:    slot_byte = b3_hold_q;
                4'd2:    slot_byte = C2_BYTE;
                4'd3:    slot_byte = WIDTH'({rei_lat_q, rdi_lat_q, 3'b000});
                4'd5:    slot_byte = WIDTH'({6'b111111, mfi_q});
                default: slot_byte = '0;
            endcase
        end
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        k_d   = k_q;
        mfi_d = mfi_q;
        if (sof) begin
            col_d = 9'd1;
            row_d = 4'd0;
            k_d   = 2'd0;
        end else if (en_vc4_i && sync_q) begin
            if (col_q == LAST_COL) begin
                col_d = 9'd0;
                k_d   = 2'd0;
                if (row_q == LAST_ROW) begin
                    row_d = 4'd0;
                    mfi_d = mfi_q + 2'd1;
                end else begin
                    row_d = row_q + 4'd1;
                end
            end else begin
                col_d = col_q + 9'd1;
                if (col_q >= 9'd3) begin
                    k_d = (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
                end else begin
                    k_d = 2'd0;
                end
            end
        end
    end

    always_comb begin
        vc4dout_o = byte_q;
        if (tug_sel_q) begin
            case (tug_k_q)
                2'd0:    vc4dout_o = dotug3_0_i;
                2'd1:    vc4dout_o = dotug3_1_i;
                default: vc4dout_o = dotug3_2_i;
            endcase
        end
    end

    // B3 folds the bytes as they leave; a resync drops whatever the old frame had collected.
    always_comb begin
        b3_acc_d  = b3_acc_q;
        b3_hold_d = b3_hold_q;
        if (vld_q) begin
            if (last_q) begin
                b3_hold_d = b3_acc_q ^ vc4dout_o;
                b3_acc_d  = '0;
            end else begin
                b3_acc_d = b3_acc_q ^ vc4dout_o;
            end
        end
        if (sof) begin
            b3_acc_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            col_q     <= '0;
            row_q     <= '0;
            k_q       <= '0;
            mfi_q     <= '0;
            sync_q    <= 1'b0;
            b3_acc_q  <= '0;
            b3_hold_q <= '0;
            rei_lat_q <= '0;
            rdi_lat_q <= 1'b0;
            byte_q    <= '0;
            tug_sel_q <= 1'b0;
            tug_k_q   <= '0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
            sof_err_q <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            k_q       <= k_d;
            mfi_q     <= mfi_d;
            sync_q    <= sync_q | sof;
            b3_acc_q  <= b3_acc_d;
            b3_hold_q <= b3_hold_d;
            if (is_j1) begin
                rei_lat_q <= rei_clamp;
                rdi_lat_q <= rdi_i;
            end
            byte_q    <= (slot_vld && !is_tug) ? slot_byte : '0;
            tug_sel_q <= is_tug;
            tug_k_q   <= k_q;
            vld_q     <= slot_vld;
            last_q    <= is_last;
            sof_err_q <= sof & sync_q & ((col_q != 9'd0) | (row_q != 4'd0));
        end
    end

    assign do_vld_o  = vld_q;
    assign mfi_o     = mfi_q;
    assign sof_err_o = sof_err_q;

endmodule

// File: tb/tb_vc4_tx_poh.sv
// Randomised bench for vc4_tx_poh: slot-indexed reference model plus literal pins on POH bytes.
`timescale 1ns/1ps
module tb_vc4_tx_poh;

    logic       clk = 1'b0;
    logic       rst_n, txsof, en, rdi;
    logic [3:0] rei;
    logic [7:0] d0, d1, d2;
    logic       e0, e1, e2, do_vld, sof_err;
    logic [7:0] dout;
    logic [1:0] mfi;

    always #5 clk = ~clk;

    vc4_tx_poh dut (
        .clk_i(clk), .rst_n_i(rst_n), .txsof_i(txsof), .en_vc4_i(en),
        .dotug3_0_i(d0), .dotug3_1_i(d1), .dotug3_2_i(d2),
        .rei_cnt_i(rei), .rdi_i(rdi),
        .entug3_0_o(e0), .entug3_1_o(e1), .entug3_2_o(e2),
        .vc4dout_o(dout), .do_vld_o(do_vld), .mfi_o(mfi), .sof_err_o(sof_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Source data: per-TUG byte sequence, either constant A0|k or a deterministic pattern.
    bit const_mode = 1'b1;
    function automatic logic [7:0] src_byte(input int k, input int n);
        if (const_mode) return 8'hA0 | 8'(k);
        return 8'((n * 37) + (k * 91) + (n >> 2) + 5);
    endfunction

    logic [7:0] nd [3];
    int         src_n [3];

    // Reference model state: linear slot index within the frame.
    bit         m_sync;
    int         m_p, m_frame;
    logic [1:0] m_mfi;
    logic [7:0] m_acc, m_hold;
    logic [3:0] m_rei;
    logic       m_rdi;
    int         m_n [3];
    bit         pv, perr;
    logic [7:0] pb;
    int         pf, pp;

    logic [7:0] b3_cap [32];
    logic [7:0] h4_cap [32];
    logic [7:0] g1_cap [32];
    logic [7:0] first3 [3];
    int         nvalid = 0;
    int         req_f0 [3];
    int         sof_err_cnt = 0;
    int         unsync_cnt = 0;

    initial begin
        m_frame = -1;
        for (int k = 0; k < 3; k++) req_f0[k] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outputs", {e2, e1, e0, do_vld, dout, mfi, sof_err}, 0);
                m_sync = 0; m_p = 0; m_mfi = 0; m_acc = 0; m_hold = 0;
                m_rei = 0; m_rdi = 0; pv = 0; perr = 0;
                for (int k = 0; k < 3; k++) begin
                    m_n[k] = 0; src_n[k] = 0; nd[k] = 8'($urandom);
                end
            end else begin
                int col, row, k;
                logic [2:0] exp_req, act_req;
                logic [7:0] b;
                col = m_p % 261;
                row = m_p / 261;
                exp_req = 3'b000;
                if (en && m_sync && !txsof && col >= 3) exp_req[(col - 3) % 3] = 1'b1;
                act_req = {e2, e1, e0};
                chk("entug", act_req, exp_req);
                chk("do_vld", do_vld, pv);
                if (pv) begin
                    chk("vc4dout", dout, pb);
                    if (pf >= 0 && pf < 32) begin
                        if (pp == 261)     b3_cap[pf] = dout;
                        if (pp == 3 * 261) g1_cap[pf] = dout;
                        if (pp == 5 * 261) h4_cap[pf] = dout;
                    end
                    if (nvalid < 3) first3[nvalid] = dout;
                    nvalid++;
                end
                chk("mfi", mfi, m_mfi);
                chk("sof_err", sof_err, perr);
                if (sof_err) sof_err_cnt++;
                if (!m_sync && act_req != 0) unsync_cnt++;
                for (int j = 0; j < 3; j++) begin
                    if (m_frame == 0 && m_sync && act_req[j]) req_f0[j]++;
                    if (act_req[j]) begin
                        nd[j] = src_byte(j, src_n[j]);
                        src_n[j]++;
                    end else begin
                        nd[j] = 8'($urandom);
                    end
                end
                // advance the model by one slot
                pv = 0; perr = 0;
                if (en) begin
                    if (txsof) begin
                        perr = m_sync && (m_p != 0);
                        m_sync = 1; m_p = 0; m_acc = 0; m_frame++;
                        pv = 1;
                    end else if (m_sync) begin
                        pv = 1;
                    end
                    if (pv) begin
                        col = m_p % 261;
                        row = m_p / 261;
                        if (m_p == 0) begin
                            m_rei = (rei > 8) ? 4'd8 : rei;
                            m_rdi = rdi;
                        end
                        b = 8'h00;
                        if (col == 0) begin
                            case (row)
                                0: b = 8'h00;
                                1: b = m_hold;
                                2: b = 8'h02;
                                3: b = {m_rei, m_rdi, 3'b000};
                                5: b = {6'h3F, m_mfi};
                                default: b = 8'h00;
                            endcase
                        end else if (col >= 3) begin
                            k = (col - 3) % 3;
                            b = src_byte(k, m_n[k]);
                            m_n[k]++;
                        end
                        pb = b; pf = m_frame; pp = m_p;
                        m_acc ^= b;
                        if (m_p == 9 * 261 - 1) begin
                            m_hold = m_acc; m_acc = 0; m_mfi = m_mfi + 2'd1;
                            m_p = 0; m_frame++;
                        end else begin
                            m_p++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            d0 = nd[0]; d1 = nd[1]; d2 = nd[2];
        end
    end

    bit rnd_poh = 1'b0;
    task automatic step(input bit e, input bit s);
        en = e;
        txsof = s;
        if (rnd_poh) begin
            rei = 4'($urandom_range(0, 15));
            rdi = 1'($urandom);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 99) < gap_pct) step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] h4_exp [5];
        logic [7:0] b3_exp [5];
        h4_exp = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'hFC};
        b3_exp = '{8'h00, 8'hFE, 8'h01, 8'hFD, 8'h00};
        rst_n = 1'b0; txsof = 1'b0; en = 1'b0; rei = 4'd0; rdi = 1'b0;
        d0 = 8'h00; d1 = 8'h00; d2 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // gapless constant-data frames: pins J1/stuff, request counts, H4 walk and B3 chain
        step(1'b1, 1'b1);
        run(5 * 2349 - 1, 0);
        for (int i = 0; i < 3; i++) chk("first_bytes", first3[i], 8'h00);
        for (int k = 0; k < 3; k++) chk("tug_requests_frame0", req_f0[k], 86 * 9);
        for (int f = 0; f < 5; f++) begin
            chk("h4_byte", h4_cap[f], h4_exp[f]);
            chk("b3_byte", b3_cap[f], b3_exp[f]);
        end

        // gapped random-data frames with G1 pins
        const_mode = 1'b0;
        rei = 4'd5; rdi = 1'b1;
        run(2349, 30);
        rei = 4'd12; rdi = 1'b0;
        run(2349, 30);
        chk("g1_rei5_rdi1", g1_cap[5], 8'h58);
        chk("g1_rei12_clamped", g1_cap[6], 8'h80);

        // resync at row 4, col 100
        rnd_poh = 1'b1;
        run(4 * 261 + 100, 30);
        step(1'b1, 1'b1);
        run(2349 + 300, 30);
        chk("sof_err_pulses", sof_err_cnt, 1);

        // asynchronous reset mid-row
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {e2, e1, e0, do_vld, dout, mfi, sof_err}, 0);
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        unsync_cnt = 0;
        run(50, 0);
        chk("no_request_before_txsof", unsync_cnt, 0);
        step(1'b1, 1'b1);
        run(600, 20);
        en = 1'b0;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
